// File: rtl/regfile_pkg.sv
// Shared types and constants for the ID-stage integer register file.
package regfile_pkg;

    localparam int XLEN_DEFAULT         = 32;
    localparam int NREGS_DEFAULT        = 32;
    localparam int MAX_INFLIGHT_DEFAULT = 3;

    typedef logic [4:0]              reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xlen_t;

    localparam reg_addr_t REG_ZERO         = 5'd0;
    localparam reg_addr_t REG_SP           = 5'd2;
    localparam xlen_t     SP_RESET_DEFAULT = 32'h0000_3FFC;

endpackage

// File: rtl/id_regfile_if.sv
// Writeback-to-ID interface: the writeback stage drives it, the register file sinks it.
interface id_regfile_if #(
    parameter int XLEN = 32
);
    logic            WB_ID_regwrite;
    logic            WB_ID_fpusrc;
    logic [4:0]      WB_ID_rd;
    logic [XLEN-1:0] WB_ID_res;
    logic            WB_ID_retire;

    modport master (
        output WB_ID_regwrite, WB_ID_fpusrc, WB_ID_rd, WB_ID_res, WB_ID_retire
    );

    modport slave (
        input WB_ID_regwrite, WB_ID_fpusrc, WB_ID_rd, WB_ID_res, WB_ID_retire
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register count of issued-but-not-retired writes, hazard detect and sticky error.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS        = NREGS_DEFAULT,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT
) (
    input  logic      clk,
    input  logic      Rst,
    input  logic      dbg,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    input  logic      retire,
    input  reg_addr_t retire_rd,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    input  logic      rs1_used,
    input  logic      rs2_used,
    output logic      hazard,
    output logic      sb_err
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_MAX = cnt_t'(MAX_INFLIGHT);

    cnt_t             cnt_q [NREGS];
    cnt_t             cnt_d [NREGS];
    logic             sb_err_q;
    logic             sb_err_d;
    logic [NREGS-1:0] inc_v;
    logic [NREGS-1:0] dec_v;

    // Decode issue/retire pulses into per-register strobes; x0 is never tracked.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int i = 1; i < NREGS; i++) begin
            inc_v[i] = issue_valid && (issue_rd == reg_addr_t'(i));
            dec_v[i] = retire && (retire_rd == reg_addr_t'(i));
        end
    end

    // Counter next state: saturate at both ends and flag the error; frozen in debug.
    always_comb begin
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        if (!dbg) begin
            for (int i = 1; i < NREGS; i++) begin
                if (inc_v[i] && !dec_v[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        sb_err_d = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + cnt_t'(1);
                    end
                end else if (dec_v[i] && !inc_v[i]) begin
                    if (cnt_q[i] == '0) begin
                        sb_err_d = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - cnt_t'(1);
                    end
                end
            end
        end
    end

    // Counter and error state registers.
    always_ff @(posedge clk) begin
        if (Rst) begin
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Uses the registered count, so a retire on this edge only clears hazard next cycle.
    assign hazard = (rs1_used && (rs1_addr != REG_ZERO) && (cnt_q[rs1_addr] != '0)) ||
                    (rs2_used && (rs2_addr != REG_ZERO) && (cnt_q[rs2_addr] != '0));
    assign sb_err = sb_err_q;

endmodule

// File: rtl/id_regfile.sv
// ID-stage integer register file: writeback sink, two registered read ports with
// same-edge bypass, combinational debug port, and the in-flight scoreboard.
module id_regfile
    import regfile_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter int              NREGS        = NREGS_DEFAULT,
    parameter logic [XLEN-1:0] SP_RESET     = SP_RESET_DEFAULT,
    parameter int              MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             dbg,
    input  logic             stall,
    id_regfile_if.slave      wb,
    input  logic             issue_valid,
    input  reg_addr_t        issue_rd,
    input  reg_addr_t        rs1_addr,
    input  reg_addr_t        rs2_addr,
    input  logic             rs1_used,
    input  logic             rs2_used,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             hazard,
    input  reg_addr_t        dbg_addr,
    output logic [XLEN-1:0]  dbg_data,
    output logic             sb_err
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs1_data_d;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] rs2_data_d;
    logic            wr_en;

    // FP-targeted writebacks share the bus but belong to the other file.
    assign wr_en = wb.WB_ID_regwrite && !wb.WB_ID_fpusrc && (wb.WB_ID_rd != REG_ZERO);

    // Read-port next state: forward same-edge writeback data, hold on stall or debug.
    always_comb begin
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        if (!stall && !dbg) begin
            if (rs1_addr == REG_ZERO) begin
                rs1_data_d = '0;
            end else if (wr_en && (wb.WB_ID_rd == rs1_addr)) begin
                rs1_data_d = wb.WB_ID_res;
            end else begin
                rs1_data_d = regs_q[rs1_addr];
            end
            if (rs2_addr == REG_ZERO) begin
                rs2_data_d = '0;
            end else if (wr_en && (wb.WB_ID_rd == rs2_addr)) begin
                rs2_data_d = wb.WB_ID_res;
            end else begin
                rs2_data_d = regs_q[rs2_addr];
            end
        end
    end

    // Storage array; writes are not gated by stall or debug.
    always_ff @(posedge clk) begin
        if (Rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
            end
        end else if (wr_en) begin
            regs_q[wb.WB_ID_rd] <= wb.WB_ID_res;
        end
    end

    // Registered read outputs.
    always_ff @(posedge clk) begin
        if (Rst) begin
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    assign rs1_data = rs1_data_q;
    assign rs2_data = rs2_data_q;
    assign dbg_data = (dbg_addr == REG_ZERO) ? '0 : regs_q[dbg_addr];

    regfile_scoreboard #(
        .NREGS        (NREGS),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_scoreboard (
        .clk         (clk),
        .Rst         (Rst),
        .dbg         (dbg),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .retire      (wb.WB_ID_retire),
        .retire_rd   (wb.WB_ID_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used),
        .hazard      (hazard),
        .sb_err      (sb_err)
    );

endmodule

// File: doc/id_regfile.md
Name: id_regfile

Overview:
- Integer register file on the ID side of the pipeline. It is the consumer of the writeback interface: it sinks WB_ID_rd, WB_ID_res and WB_ID_regwrite, and serves two registered read ports to decode.
- It also holds a per-register in-flight scoreboard. The scoreboard counts issued-but-not-retired writes per register and drives the ID hazard outputs.
- It sits inside ID, beside the hazard unit. The debug controller reads registers through a third port.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, number of architectural registers; address width is log2(NREGS).
- SP_RESET, 32'h0000_3FFC, reset value of x2.
- MAX_INFLIGHT, 3, per-register scoreboard count limit; counter width is clog2(MAX_INFLIGHT+1).

Ports:
- clk  in  1  core clock
- Rst  in  1  synchronous active-high reset
- dbg  in  1  debug halt; freezes reads and scoreboard, writes still land
- stall  in  1  ID stall (mem_hold | f_stall | hazard); holds read outputs
- WB_ID_regwrite  in  1  writeback write enable
- WB_ID_fpusrc  in  1  write targets the FP file; ignored here
- WB_ID_rd  in  5  writeback destination
- WB_ID_res  in  XLEN  writeback data
- WB_ID_retire  in  1  one-cycle pulse per retiring scoreboarded instruction; rd = WB_ID_rd
- issue_valid  in  1  one-cycle pulse: instruction with integer rd leaves ID
- issue_rd  in  5  destination of the issuing instruction
- rs1_addr, rs2_addr  in  5 each  read addresses
- rs1_used, rs2_used  in  1 each  operand is actually read
- rs1_data, rs2_data  out  XLEN each  registered read data
- hazard  out  1  combinational: a used operand has in-flight writes
- dbg_addr  in  5  debug read address
- dbg_data  out  XLEN  combinational debug read
- sb_err  out  1  sticky scoreboard over- or underflow

Behaviour:
- Reset (Rst=1 at a clk edge):
  - All registers become 0, except x2, which becomes SP_RESET.
  - All scoreboard counters become 0.
  - rs1_data, rs2_data and sb_err become 0.
  - Rst takes precedence over every other input on the same edge.
- Write:
  - Occurs at the edge when WB_ID_regwrite=1, WB_ID_fpusrc=0 and WB_ID_rd!=0.
  - Not gated by stall or dbg; a held WB_ID value rewrites the same data, which is idempotent.
  - Writes to x0 are dropped.
- Read:
  - Latency is 1 cycle. When stall=0 and dbg=0, rsN_data <= (rsN_addr==0) ? 0 : bypass(rsN_addr).
  - bypass(a) returns WB_ID_res if a write to address a occurs on the same edge; otherwise it returns regs[a].
  - When stall=1 or dbg=1, rsN_data holds its value.
- Debug read: dbg_data = regs[dbg_addr], combinational, with no bypass; x0 reads as 0.
- Scoreboard, one counter per register with x0 excluded. Update happens only when dbg=0; during dbg every counter holds.
  - issue only (issue_valid=1 and issue_rd!=0): counter increments.
  - retire only (WB_ID_retire=1 and WB_ID_rd!=0): counter decrements.
  - Issue and retire to the same register on the same edge: counter unchanged.
  - Issue and retire to different registers: both updates apply.
  - Increment when the counter already equals MAX_INFLIGHT: counter saturates and sb_err <= 1.
  - Decrement when the counter is 0: counter stays 0 and sb_err <= 1.
  - sb_err clears only on Rst.
- Retire semantics: squashed instructions still send WB_ID_retire with WB_ID_regwrite=0. The counter therefore decrements and no write occurs.
- Hazard:
  - hazard = (rs1_used & rs1_addr!=0 & cnt[rs1_addr]!=0) | (rs2_used & rs2_addr!=0 & cnt[rs2_addr]!=0).
  - A retire on the current edge does not clear hazard in that cycle. This is conservative; it clears in the next cycle.
- The issue/retire pulse discipline belongs to the producers. This block counts every asserted pulse exactly once.

Decomposition:
- Shared package regfile_pkg holds:
  - typedef reg_addr_t (logic [4:0]);
  - typedef xlen_t (logic [XLEN-1:0]);
  - constants REG_ZERO=0, REG_SP=2 and SP_RESET_DEFAULT.
- One natural sub-module, regfile_scoreboard. It owns the counter array, the hazard logic and sb_err. The storage array and read ports stay in id_regfile.

Test Plan:
1. Rst for 2 cycles, then read x1/x2 with stall=0: after one cycle rs1_data=0, rs2_data=32'h3FFC, sb_err=0, hazard=0.
2. Write rd=5, res=32'hDEAD_BEEF with rs1_addr=5 on the same edge: next cycle rs1_data=32'hDEADBEEF (bypass). Write rd=0, res=32'h1234, then read x0: returns 0.
3. stall=1 while the write to x7=32'hA5A5 lands and rs1_addr=7: rs1_data keeps its old value. Drop stall: next cycle rs1_data=32'hA5A5 and dbg_data(7)=32'hA5A5.
4. Two issues to x3, rs1_addr=3, rs1_used=1: hazard=1.
   - First retire: still 1.
   - Second retire: hazard=0 the following cycle.
   - Simultaneous issue and retire of x3 at count 1: count stays 1, hazard stays 1.
5. Four issues to x4 with MAX_INFLIGHT=3: count saturates at 3 and sb_err=1. A retire to x6 at count 0 leaves count 0.
6. Assert Rst while x3's count=2 and rs1_data=32'hFFFF: next cycle all counts=0, hazard=0, rs1_data=0, x2=32'h3FFC.
